// File: rtl/spi_regmap_pkg.sv
// Shared register addresses and constants for the SPI register bank.
// The PHY bench and firmware headers use the same address map.
package spi_regmap_pkg;

    localparam logic [6:0] ADDR_ID        = 7'h00;
    localparam logic [6:0] ADDR_VER       = 7'h01;
    localparam logic [6:0] ADDR_SCRATCH   = 7'h02;
    localparam logic [6:0] ADDR_CTRL      = 7'h03;
    localparam logic [6:0] ADDR_STATUS    = 7'h04;
    localparam logic [6:0] ADDR_IRQ_FLAGS = 7'h05;
    localparam logic [6:0] ADDR_IRQ_MASK  = 7'h06;
    localparam logic [6:0] ADDR_CMD       = 7'h07;
    localparam logic [6:0] ADDR_ERR_CNT   = 7'h08;
    localparam logic [6:0] ADDR_GP_BASE   = 7'h10;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Writable addresses outside the GP window; CMD is a legal write target.
    function automatic logic fixed_writable(input logic [6:0] addr);
        return (addr == ADDR_SCRATCH) || (addr == ADDR_CTRL) || (addr == ADDR_IRQ_FLAGS) ||
               (addr == ADDR_IRQ_MASK) || (addr == ADDR_CMD);
    endfunction

endpackage

// File: rtl/spi_regmap.sv
// Register bank behind the SPI slave PHY: control, status, sticky IRQ flags,
// error counter and general-purpose registers, with a registered read port.
module spi_regmap
    import spi_regmap_pkg::*;
#(
    parameter logic [7:0] ID_VALUE  = 8'hA5,
    parameter logic [7:0] VER_VALUE = 8'h01,
    parameter logic [7:0] CTRL_RST  = 8'h00,
    parameter int         NUM_GP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_wr_en,
    input  logic [6:0]            rx_addr,
    input  logic [7:0]            rx_data,
    output logic [7:0]            tx_data,
    input  logic [7:0]            status_in,
    input  logic [7:0]            event_in,
    output logic [7:0]            ctrl_out,
    output logic [7:0]            cmd_pulse,
    output logic [8*NUM_GP-1:0]   gp_out,
    output logic                  irq
);

    // Write interface: no handshake; every rx_wr_en pulse is accepted and applied
    // at the same clk edge. Reads are continuous: tx_data follows rx_addr one cycle later.

    logic [7:0]        scratch;
    logic [7:0]        ctrl;
    logic [7:0]        status_q;
    logic [7:0]        flags;
    logic [7:0]        mask;
    logic [7:0]        err_cnt;
    logic [7:0]        gp_q [NUM_GP];
    logic [NUM_GP-1:0] gp_sel;
    logic [7:0]        flags_next;
    logic [7:0]        mask_next;
    logic [7:0]        rd_data;
    logic              wr_legal;

    genvar k;
    generate
        for (k = 0; k < NUM_GP; k++) begin : g_gp
            localparam logic [6:0] GP_ADDR = ADDR_GP_BASE + 7'(k);
            assign gp_sel[k]           = (rx_addr == GP_ADDR);
            assign gp_out[8*k +: 8]    = gp_q[k];
        end
    endgenerate

    assign wr_legal = fixed_writable(rx_addr) || (|gp_sel);
    assign ctrl_out = ctrl;

    // A same-cycle event wins over a W1C of the same bit.
    always_comb begin
        flags_next = (flags & ~((rx_wr_en && rx_addr == ADDR_IRQ_FLAGS) ? rx_data : 8'h00))
                     | event_in;
        mask_next  = (rx_wr_en && rx_addr == ADDR_IRQ_MASK) ? rx_data : mask;
    end

    always_comb begin
        rd_data = 8'h00;
        case (rx_addr)
            ADDR_ID:        rd_data = ID_VALUE;
            ADDR_VER:       rd_data = VER_VALUE;
            ADDR_SCRATCH:   rd_data = scratch;
            ADDR_CTRL:      rd_data = ctrl;
            ADDR_STATUS:    rd_data = status_q;
            ADDR_IRQ_FLAGS: rd_data = flags;
            ADDR_IRQ_MASK:  rd_data = mask;
            ADDR_CMD:       rd_data = 8'h00;
            ADDR_ERR_CNT:   rd_data = err_cnt;
            default: begin
                for (int i = 0; i < NUM_GP; i++) begin
                    if (gp_sel[i]) rd_data = gp_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch   <= 8'h00;
            ctrl      <= CTRL_RST;
            status_q  <= 8'h00;
            flags     <= 8'h00;
            mask      <= 8'h00;
            err_cnt   <= 8'h00;
            tx_data   <= 8'h00;
            cmd_pulse <= 8'h00;
            irq       <= 1'b0;
            for (int i = 0; i < NUM_GP; i++) gp_q[i] <= 8'h00;
        end else begin
            status_q  <= status_in;
            flags     <= flags_next;
            mask      <= mask_next;
            irq       <= |(flags_next & mask_next);
            tx_data   <= rd_data;
            cmd_pulse <= (rx_wr_en && rx_addr == ADDR_CMD) ? rx_data : 8'h00;
            if (rx_wr_en && rx_addr == ADDR_SCRATCH) scratch <= rx_data;
            if (rx_wr_en && rx_addr == ADDR_CTRL)    ctrl    <= rx_data;
            for (int i = 0; i < NUM_GP; i++) begin
                if (rx_wr_en && gp_sel[i]) gp_q[i] <= rx_data;
            end
            // Error counter saturates instead of wrapping.
            if (rx_wr_en && !wr_legal && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_regmap.sv
// Bench for spi_regmap: directed vector table, randomized traffic against a
// register-map model, a bit-level SPI PHY model and reset-during-write sequences.
module tb_spi_regmap;

    localparam int         NUM_GP   = 4;
    localparam logic [7:0] CTRL_RST = 8'h00;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                rx_wr_en = 1'b0;
    logic [6:0]          rx_addr = '0;
    logic [7:0]          rx_data = '0;
    logic [7:0]          tx_data;
    logic [7:0]          status_in = '0;
    logic [7:0]          event_in = '0;
    logic [7:0]          ctrl_out;
    logic [7:0]          cmd_pulse;
    logic [8*NUM_GP-1:0] gp_out;
    logic                irq;

    spi_regmap #(.ID_VALUE(8'hA5), .VER_VALUE(8'h01), .CTRL_RST(CTRL_RST), .NUM_GP(NUM_GP)) dut (
        .clk(clk), .reset(reset), .rx_wr_en(rx_wr_en), .rx_addr(rx_addr), .rx_data(rx_data),
        .tx_data(tx_data), .status_in(status_in), .event_in(event_in), .ctrl_out(ctrl_out),
        .cmd_pulse(cmd_pulse), .gp_out(gp_out), .irq(irq)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // register-map model
    logic [7:0] m_rw [128];
    logic [7:0] m_flags, m_status, m_cmd;
    int         m_err;
    logic       m_irq;

    function automatic bit m_is_gp(input logic [6:0] a);
        return (int'(a) >= 16) && (int'(a) < 16 + NUM_GP);
    endfunction

    function automatic bit m_legal(input logic [6:0] a);
        return (a == 7'h02) || (a == 7'h03) || (a == 7'h05) || (a == 7'h06) || (a == 7'h07) || m_is_gp(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_rw[i] = 8'h00;
        m_rw[3] = CTRL_RST;
        m_flags = 0; m_status = 0; m_cmd = 0; m_err = 0; m_irq = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        case (a)
            7'h00: return 8'hA5;
            7'h01: return 8'h01;
            7'h02, 7'h03, 7'h06: return m_rw[a];
            7'h04: return m_status;
            7'h05: return m_flags;
            7'h08: return 8'(m_err);
            default: return m_is_gp(a) ? m_rw[a] : 8'h00;
        endcase
    endfunction

    task automatic model_update(input logic wr, input logic [6:0] a, input logic [7:0] d,
                                input logic [7:0] ev, input logic [7:0] st);
        m_cmd = 8'h00;
        if (wr) begin
            if (m_legal(a)) begin
                if (a == 7'h05)      m_flags = m_flags & ~d;
                else if (a == 7'h07) m_cmd = d;
                else                 m_rw[a] = d;
            end else if (m_err < 255) begin
                m_err = m_err + 1;
            end
        end
        m_flags  = m_flags | ev;
        m_status = st;
        m_irq    = |(m_flags & m_rw[6]);
    endtask

    function automatic logic [31:0] model_gp();
        logic [31:0] g;
        for (int i = 0; i < NUM_GP; i++) g[8*i +: 8] = m_rw[16+i];
        return g;
    endfunction

    // driver tasks
    task automatic step(input logic wr, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] ev, input logic [7:0] st);
        rx_wr_en = wr; rx_addr = a; rx_data = d; event_in = ev; status_in = st;
        exp_q.push_back(model_read(a));
        model_update(wr, a, d, ev, st);
        @(posedge clk); #1;
        check("tx_data", tx_data, exp_q.pop_front());
        check("cmd_pulse", cmd_pulse, m_cmd);
        check("irq", irq, m_irq);
        check("ctrl_out", ctrl_out, m_rw[3]);
        check("gp_out", gp_out, model_gp());
        rx_wr_en = 0; event_in = 0;
    endtask

    task automatic do_reset();
        reset = 1; rx_wr_en = 0; event_in = 0; status_in = 0; rx_addr = 0; rx_data = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_ctrl_out", ctrl_out, CTRL_RST);
        check("rst_irq", irq, 1'b0);
        check("rst_gp_out", gp_out, 32'h0);
        check("rst_cmd_pulse", cmd_pulse, 8'h00);
        reset = 0;
    endtask

    // PHY model: SCK = clk/4, frame = {rw, addr[6:0], data[7:0]}, MSB first.
    task automatic spi_xfer(input logic [15:0] frame, output logic [7:0] miso);
        logic [15:0] sh;
        logic [6:0]  pa;
        logic        rw;
        logic [7:0]  tx_latch;
        sh = 0; pa = 0; rw = 0; tx_latch = 0; miso = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, pa, 8'h00, 8'h00, 8'h00);
            if (i == 8) tx_latch = tx_data;
            step(0, pa, 8'h00, 8'h00, 8'h00);
            sh = {sh[14:0], frame[15-i]};
            if (i >= 8) miso = {miso[6:0], tx_latch[15-i]};
            step(0, pa, 8'h00, 8'h00, 8'h00);
            step(0, pa, 8'h00, 8'h00, 8'h00);
            if (i == 7) begin
                rw = sh[7];
                pa = sh[6:0];
            end
        end
        if (!rw) step(1, pa, sh[7:0], 8'h00, 8'h00);
    endtask

    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] ev;
        logic [7:0] exp_tx;
        logic [7:0] exp_cmd;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [7:0] miso;
        logic [6:0] a;
        int         r;

        // wr, addr, data, event, expected tx_data / cmd_pulse / irq after the edge
        vecs[0]  = '{1'b0, 7'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 7'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 7'h02, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 7'h02, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 7'h13, 8'h7E, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 7'h13, 8'h00, 8'h00, 8'h7E, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 7'h07, 8'h81, 8'h00, 8'h00, 8'h81, 1'b0};
        vecs[7]  = '{1'b0, 7'h07, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 7'h06, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 7'h06, 8'h00, 8'h04, 8'h04, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 7'h05, 8'h00, 8'h00, 8'h04, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 7'h05, 8'h04, 8'h04, 8'h04, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 7'h05, 8'h00, 8'h00, 8'h04, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 7'h05, 8'h04, 8'h00, 8'h04, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 7'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 7'h00, 8'hFF, 8'h00, 8'hA5, 8'h00, 1'b0};
        vecs[16] = '{1'b1, 7'h04, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[17] = '{1'b1, 7'h7F, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[18] = '{1'b0, 7'h08, 8'h00, 8'h00, 8'h03, 8'h00, 1'b0};
        vecs[19] = '{1'b0, 7'h03, 8'h00, 8'h00, CTRL_RST, 8'h00, 1'b0};

        do_reset();

        foreach (vecs[i]) begin
            rx_wr_en = vecs[i].wr; rx_addr = vecs[i].addr; rx_data = vecs[i].data;
            event_in = vecs[i].ev; status_in = 8'h00;
            exp_q.push_back(vecs[i].exp_tx);
            model_update(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].ev, 8'h00);
            @(posedge clk); #1;
            check($sformatf("vec%0d_tx", i), tx_data, exp_q.pop_front());
            check($sformatf("vec%0d_cmd", i), cmd_pulse, vecs[i].exp_cmd);
            check($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
            rx_wr_en = 0; event_in = 0;
        end
        check("gp3_out", gp_out[31:24], 8'h7E);

        // ERR_CNT saturation
        repeat (260) step(1, 7'h7F, 8'h00, 8'h00, 8'h00);
        step(0, 7'h08, 8'h00, 8'h00, 8'h00);
        check("err_sat", tx_data, 8'hFF);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      a = 7'($urandom_range(0, 127));
            else if (r == 1) a = 7'(16 + $urandom_range(0, 5));
            else             a = 7'($urandom_range(0, 8));
            step(1'($urandom_range(0, 1)), a, 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom));
        end

        // end-to-end through the PHY model
        do_reset();
        spi_xfer({1'b0, 7'h02, 8'h5A}, miso);
        step(0, 7'h02, 8'h00, 8'h00, 8'h00);
        check("spi_wr_scratch", tx_data, 8'h5A);
        spi_xfer({1'b1, 7'h02, 8'h00}, miso);
        check("spi_rd_miso", miso, 8'h5A);

        // reset coinciding with a write strobe: write, pulse and error are all dropped
        step(1, 7'h7F, 8'h00, 8'h00, 8'h00);
        reset = 1; rx_wr_en = 1; rx_addr = 7'h02; rx_data = 8'h77;
        @(posedge clk); #1;
        rx_addr = 7'h07; rx_data = 8'h99;
        @(posedge clk); #1;
        model_reset();
        check("rst_wr_cmd_pulse", cmd_pulse, 8'h00);
        reset = 0; rx_wr_en = 0;
        step(0, 7'h02, 8'h00, 8'h00, 8'h00);
        check("rst_wr_scratch", tx_data, 8'h00);
        step(0, 7'h08, 8'h00, 8'h00, 8'h00);
        check("rst_wr_err_cnt", tx_data, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
